// File: rtl/vr_burst_pkg.sv
// -----------------------------------------------------------------------------
// vr_burst_pkg
// Shared types and width helpers for the burst framer and its FIFO.
//   state_t  : framer FSM state encoding (ST_FLUSH exists only when the
//              optional partial-flush feature is built in).
//   lvl_w    : width of a level/beat counter able to hold 0..DEPTH.
//   ptr_w    : width of a FIFO address for DEPTH entries.
//   idle_w   : width of a counter able to hold 0..FLUSH_CYCLES.
// Optional feature macro: VR_BURST_FLUSH_EN.
// -----------------------------------------------------------------------------
package vr_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1
`ifdef VR_BURST_FLUSH_EN
    ,
    ST_FLUSH = 2'd2
`endif
  } state_t;

  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned idle_w(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/vr_burst_fifo.sv
// -----------------------------------------------------------------------------
// vr_burst_fifo
// Synchronous first-word-fall-through FIFO with occupancy tracking.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (pointers/level)
//   i_push, i_data : write request and word (ignored when full)
//   i_pop          : read request (ignored when empty)
//   o_data         : head word, valid whenever !o_empty
//   o_full/o_empty : occupancy flags
//   o_level        : words currently stored
//   o_level_next   : occupancy after this cycle's push/pop
// -----------------------------------------------------------------------------
module vr_burst_fifo
  import vr_burst_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level,
  output logic [$clog2(DEPTH):0] o_level_next
);

  localparam int unsigned AW    = ptr_w(DEPTH);
  localparam int unsigned LVL_W = lvl_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] w_level_next;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_next;
    end
  end

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LVL_W'(1);
      2'b01:   w_level_next = r_level - LVL_W'(1);
      default: w_level_next = r_level;
    endcase
  end

  assign o_data       = r_mem[r_rd_ptr];
  assign o_level      = r_level;
  assign o_level_next = w_level_next;

endmodule

// File: rtl/vr_burst_framer.sv
// -----------------------------------------------------------------------------
// vr_burst_framer
// Buffers a valid/ready word stream and re-emits it as fixed-length bursts of
// BURST_LEN beats, with out_blast marking the final beat of each burst.
// Bursts follow each other without a gap while enough words are buffered.
// Optional feature macro: VR_BURST_FLUSH_EN -- when defined, a partially
// filled buffer left idle for FLUSH_CYCLES cycles is emitted as a short burst.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_data/in_valid      : upstream word and its valid
//   in_ready              : registered, high when the buffer is not full
//   out_bdata/out_bvalid  : burst beat and its valid (data = buffer head)
//   out_bready            : downstream accepts the current beat
//   out_blast             : current beat is the last of its burst
//   level                 : words currently buffered
// -----------------------------------------------------------------------------
module vr_burst_framer
  import vr_burst_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned BURST_LEN    = 8,
  parameter int unsigned FLUSH_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_bdata,
  output logic                   out_bvalid,
  input  logic                   out_bready,
  output logic                   out_blast,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned       LVL_W   = lvl_w(DEPTH);
  localparam logic [LVL_W-1:0]  BL_L    = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0]  DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  ONE_L   = LVL_W'(1);

  if (BURST_LEN == 0 || BURST_LEN > DEPTH || FLUSH_CYCLES == 0 ||
      (DEPTH & (DEPTH - 1)) != 0) begin : g_cfg_err
    $error("vr_burst_framer: illegal parameter combination");
  end

  state_t           r_state;
  state_t           w_state_next;
  logic [LVL_W-1:0] r_beat_cnt;
  logic             r_in_ready;
  logic [LVL_W-1:0] w_level;
  logic [LVL_W-1:0] w_level_next;
  logic [WIDTH-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_last_pop;
  logic             w_load_burst;
  logic             w_load_flush;
  logic             w_bvalid;
  logic             w_blast;

  assign w_push     = in_valid && r_in_ready && !w_full;
  assign w_pop      = w_bvalid && out_bready && !w_empty;
  assign w_last_pop = w_pop && (r_beat_cnt == ONE_L);

  vr_burst_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_data       (in_data),
    .i_pop        (w_pop),
    .o_data       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_level      (w_level),
    .o_level_next (w_level_next)
  );

  // in_ready for the next cycle reflects the occupancy that cycle will see.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_in_ready <= 1'b0;
    else        r_in_ready <= (w_level_next != DEPTH_L);
  end

`ifdef VR_BURST_FLUSH_EN
  localparam int unsigned IW = idle_w(FLUSH_CYCLES);

  logic [IW-1:0] r_idle_cnt;
  logic          w_idle_run;
  logic          w_idle_hit;

  // Counts consecutive push-free idle cycles holding a partial burst.
  assign w_idle_run = (r_state == ST_IDLE) && !w_push &&
                      (w_level != '0) && (w_level < BL_L);
  assign w_idle_hit = w_idle_run && (r_idle_cnt == IW'(FLUSH_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_idle_cnt <= '0;
    else if (w_idle_run && !w_idle_hit) r_idle_cnt <= r_idle_cnt + IW'(1);
    else                               r_idle_cnt <= '0;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic. A final-beat handshake either reloads a new full burst
  // (using the post-pop occupancy, including a same-cycle push) or returns
  // to IDLE.
  always_comb begin
    w_state_next = r_state;
    w_load_burst = 1'b0;
    w_load_flush = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_level >= BL_L) begin
          w_state_next = ST_BURST;
          w_load_burst = 1'b1;
        end
`ifdef VR_BURST_FLUSH_EN
        else if (w_idle_hit) begin
          w_state_next = ST_FLUSH;
          w_load_flush = 1'b1;
        end
`endif
      end
      ST_BURST: begin
        if (w_last_pop) begin
          if (w_level_next >= BL_L) w_load_burst = 1'b1;
          else                      w_state_next = ST_IDLE;
        end
      end
`ifdef VR_BURST_FLUSH_EN
      ST_FLUSH: begin
        if (w_last_pop) w_state_next = ST_IDLE;
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    w_bvalid = 1'b0;
    w_blast  = 1'b0;
    case (r_state)
      ST_BURST: begin
        w_bvalid = 1'b1;
        w_blast  = (r_beat_cnt == ONE_L);
      end
`ifdef VR_BURST_FLUSH_EN
      ST_FLUSH: begin
        w_bvalid = 1'b1;
        w_blast  = (r_beat_cnt == ONE_L);
      end
`endif
      default: begin
        w_bvalid = 1'b0;
        w_blast  = 1'b0;
      end
    endcase
  end

  // Beats remaining in the current burst. A flush burst is sized by the
  // occupancy at entry, so words pushed during it wait for a later burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_beat_cnt <= '0;
    else if (w_load_burst) r_beat_cnt <= BL_L;
    else if (w_load_flush) r_beat_cnt <= w_level;
    else if (w_pop)        r_beat_cnt <= r_beat_cnt - ONE_L;
  end

  assign in_ready   = r_in_ready;
  assign out_bdata  = w_head;
  assign out_bvalid = w_bvalid;
  assign out_blast  = w_blast;
  assign level      = w_level;

endmodule

// File: tb/tb_vr_burst_framer.sv
module tb_vr_burst_framer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 32;
  localparam int BL    = 8;
  localparam int FC    = 64;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [WIDTH-1:0]       in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       out_bdata;
  logic                   out_bvalid;
  logic                   out_bready;
  logic                   out_blast;
  logic [$clog2(DEPTH):0] level;

  vr_burst_framer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST_LEN(BL), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_bdata(out_bdata), .out_bvalid(out_bvalid),
    .out_bready(out_bready), .out_blast(out_blast), .level(level)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // out_bready source: 0 = directed, 1 = random, 2 = toggling
  logic [1:0] br_mode;
  logic       br_dir;
  logic       r_rand_b = 1'b0;
  logic       r_tog_b  = 1'b0;
  assign out_bready = (br_mode == 2'd1) ? r_rand_b :
                      (br_mode == 2'd2) ? r_tog_b  : br_dir;

  always @(posedge clk) begin
    #1;
    r_rand_b = ($urandom_range(0, 9) < 6);
    r_tog_b  = ~r_tog_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: every accepted word is queued; every accepted beat must
  // be the oldest queued word; bursts are groups of exp_blen beats.
  logic [WIDTH-1:0] exp_q[$];
  int   exp_level = 0;
  int   beat_pos  = 0;
  int   exp_blen  = BL;
  int   n_beats   = 0;
  int   n_blasts  = 0;
  int   cyc       = 0;
  int   first_beat_cyc = 0;
  int   last_beat_cyc  = 0;
  bit   arm_first = 1'b0;
  bit   prev_stall = 1'b0;
  bit   was_rst    = 1'b1;
  logic [WIDTH-1:0] prev_d;
  logic             prev_l;
  logic [WIDTH-1:0] exp_d;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      exp_level  = 0;
      beat_pos   = 0;
      exp_blen   = BL;
      prev_stall = 1'b0;
      was_rst    = 1'b1;
    end else begin
      chk("level", 32'(level), 32'(exp_level));
      if (!was_rst) chk("in_ready", 32'(in_ready), 32'(exp_level != DEPTH));
      if (prev_stall) begin
        chk("stall_valid", 32'(out_bvalid), 32'(1));
        chk("stall_data",  32'(out_bdata),  32'(prev_d));
        chk("stall_last",  32'(out_blast),  32'(prev_l));
      end
      if (out_bvalid && out_bready) begin
        n_asserts++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL pop_when_empty observed=beat 0x%0h expected=no beat", out_bdata);
        end
        if (exp_q.size() != 0) begin
          exp_d = exp_q.pop_front();
          chk("bdata", 32'(out_bdata), 32'(exp_d));
          chk("blast", 32'(out_blast), 32'(beat_pos == exp_blen - 1));
          exp_level--;
        end
        if (arm_first) begin
          first_beat_cyc = cyc;
          arm_first = 1'b0;
        end
        last_beat_cyc = cyc;
        n_beats++;
        if (out_blast) n_blasts++;
        beat_pos++;
        if (beat_pos >= exp_blen) begin
          beat_pos = 0;
          exp_blen = BL;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        exp_level++;
      end
      prev_stall = out_bvalid && !out_bready;
      prev_d     = out_bdata;
      prev_l     = out_blast;
      was_rst    = 1'b0;
    end
  end

  task automatic push(input logic [WIDTH-1:0] d);
    int  n;
    bit  acc;
    n = 0;
    acc = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 500);
    in_valid = 1'b0;
    n_asserts++;
    assert (acc) else begin
      n_fail++;
      $error("FAIL push_timeout observed=not accepted expected=accepted word 0x%0h", d);
    end
  endtask

  task automatic wait_drain(input int limit);
    int k;
    k = 0;
    while ((level != 0 || out_bvalid) && k < limit) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    n_asserts++;
    assert (k < limit) else begin
      n_fail++;
      $error("FAIL drain_timeout observed=level %0d expected=level 0", level);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int b0, k0, hi;
  bit seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; br_mode = 2'd0; br_dir = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready),   32'(0));
    chk("rst_bvalid",   32'(out_bvalid), 32'(0));
    chk("rst_blast",    32'(out_blast),  32'(0));
    chk("rst_level",    32'(level),      32'(0));
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(in_ready), 32'(1));

    // Single burst, latency and content
    br_dir = 1'b1;
    b0 = n_beats; k0 = n_blasts;
    for (int i = 1; i <= 8; i++) push(16'(i));
    @(negedge clk);
    chk("lat_level_t1",  32'(level),      32'(8));
    chk("lat_bvalid_t1", 32'(out_bvalid), 32'(0));
    @(negedge clk);
    chk("lat_bvalid_t2", 32'(out_bvalid), 32'(1));
    chk("lat_bdata_t2",  32'(out_bdata),  32'(16'h0001));
    wait_drain(100);
    chk("single_beats",  32'(n_beats - b0),  32'(8));
    chk("single_blasts", 32'(n_blasts - k0), 32'(1));

    // Back-to-back bursts with no valid gap
    b0 = n_beats; k0 = n_blasts; arm_first = 1'b1;
    for (int i = 0; i < 16; i++) push(16'(16'h0100 + i));
    wait_drain(200);
    chk("b2b_beats",  32'(n_beats - b0),  32'(16));
    chk("b2b_blasts", 32'(n_blasts - k0), 32'(2));
    chk("b2b_span",   32'(last_beat_cyc - first_beat_cyc), 32'(15));

    // Fill to full with downstream stalled, then release
    br_dir = 1'b0;
    b0 = n_beats; k0 = n_blasts;
    for (int i = 1; i <= 32; i++) push(16'(16'h0200 + i));
    in_data = 16'h0221; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'(0));
      chk("full_level",    32'(level),    32'(32));
    end
    @(posedge clk); #1; br_dir = 1'b1;
    for (int i = 33; i <= 40; i++) push(16'(16'h0200 + i));
    wait_drain(300);
    chk("full_beats",  32'(n_beats - b0),  32'(40));
    chk("full_blasts", 32'(n_blasts - k0), 32'(5));

    // Toggling out_bready mid-burst
    br_mode = 2'd2;
    b0 = n_beats;
    for (int i = 0; i < 16; i++) push(16'($urandom));
    wait_drain(300);
    chk("toggle_beats", 32'(n_beats - b0), 32'(16));

    // Randomized traffic and backpressure
    br_mode = 2'd1;
    b0 = n_beats; k0 = n_blasts;
    for (int i = 0; i < 48; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      push(16'($urandom));
    end
    wait_drain(2000);
    chk("rand_beats",  32'(n_beats - b0),  32'(48));
    chk("rand_blasts", 32'(n_blasts - k0), 32'(6));

    // Reset mid-burst, then a clean burst
    br_mode = 2'd0; br_dir = 1'b1;
    b0 = n_beats;
    for (int i = 0; i < 8; i++) push(16'(16'h0300 + i));
    hi = 0;
    while ((n_beats - b0) < 4 && hi < 100) begin
      @(posedge clk);
      hi++;
    end
    #1; rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_bvalid",   32'(out_bvalid), 32'(0));
    chk("midrst_blast",    32'(out_blast),  32'(0));
    chk("midrst_level",    32'(level),      32'(0));
    chk("midrst_in_ready", 32'(in_ready),   32'(0));
    chk("midrst_beats",    32'(n_beats - b0), 32'(4));
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_level_rel", 32'(level), 32'(0));
    @(posedge clk); #1;
    chk("midrst_ready_rel", 32'(in_ready), 32'(1));
    b0 = n_beats; k0 = n_blasts;
    for (int i = 0; i < 8; i++) push(16'(16'h0400 + i));
    wait_drain(100);
    chk("postrst_beats",  32'(n_beats - b0),  32'(8));
    chk("postrst_blasts", 32'(n_blasts - k0), 32'(1));

    // Partial data left idle
`ifdef VR_BURST_FLUSH_EN
    b0 = n_beats; k0 = n_blasts;
    exp_blen = 3;
    for (int i = 0; i < 3; i++) push(16'(16'h0500 + i));
    seen = 1'b0;
    for (int i = 0; i < FC; i++) begin
      @(negedge clk);
      if (out_bvalid) seen = 1'b1;
    end
    chk("flush_early", 32'(seen), 32'(0));
    @(negedge clk);
    chk("flush_start", 32'(out_bvalid), 32'(1));
    wait_drain(50);
    chk("flush_beats",  32'(n_beats - b0),  32'(3));
    chk("flush_blasts", 32'(n_blasts - k0), 32'(1));
`else
    b0 = n_beats;
    for (int i = 0; i < 3; i++) push(16'(16'h0500 + i));
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_bvalid) seen = 1'b1;
    end
    chk("noflush_output", 32'(seen), 32'(0));
    chk("noflush_level",  32'(level), 32'(3));
    chk("noflush_beats",  32'(n_beats - b0), 32'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/vr_burst_framer.md
VR_BURST_FRAMER -- requirements
Module: vr_burst_framer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, buffer depth in words (power of two, >= BURST_LEN).
REQ-003 SHALL have parameter BURST_LEN, default 8, beats per full burst (1..DEPTH).
REQ-004 SHALL have parameter FLUSH_CYCLES, default 64, idle cycles before partial flush (>= 1).
REQ-005 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_data  input  WIDTH  upstream word (valid/ready downstream side).
REQ-008 SHALL have port in_valid  input  1  upstream word valid.
REQ-009 SHALL have port in_ready  output  1  block can accept a word.
REQ-010 SHALL have port out_bdata  output  WIDTH  burst beat data (burst upstream side).
REQ-011 SHALL have port out_bvalid  output  1  burst beat valid.
REQ-012 SHALL have port out_bready  input  1  downstream accepts beat.
REQ-013 SHALL have port out_blast  output  1  current beat is final beat of burst.
REQ-014 SHALL have port level  output  $clog2(DEPTH)+1  words currently buffered.

Function
REQ-015 SHALL accept a word when in_valid && in_ready; in_ready SHALL be registered and equal !full for the next cycle.
REQ-016 SHALL store accepted words in a FIFO of DEPTH entries; level SHALL update the cycle after a push/pop; simultaneous push and pop SHALL leave level unchanged.
REQ-017 SHALL implement states IDLE, BURST (plus FLUSH when configured, REQ-027).
REQ-018 IDLE: out_bvalid=0; when level >= BURST_LEN, next state BURST with beat counter = BURST_LEN.
REQ-019 BURST: out_bvalid=1 continuously until final beat accepted; out_bdata = FIFO head; no bubble between beats of a burst.
REQ-020 SHALL hold out_bdata, out_blast stable while out_bvalid && !out_bready.
REQ-021 SHALL pop FIFO and decrement beat counter on out_bvalid && out_bready; out_blast=1 exactly when beat counter == 1.
REQ-022 On final beat accept: if level after that pop (including same-cycle push) >= BURST_LEN, SHALL stay in BURST reloading counter (back-to-back bursts, no gap); else go IDLE.
REQ-023 Earliest latency: word making level reach BURST_LEN accepted at cycle t -> out_bvalid=1 at cycle t+2 (level updates t+1, state t+2).
REQ-024 Full: in_ready=0, in_valid ignored, no data loss; empty: pop never occurs (guaranteed by REQ-018).

Reset
REQ-025 While rst_n=0: in_ready=0, out_bvalid=0, out_blast=0, level=0, state IDLE, pointers, beat and flush counters 0; out_bdata don't-care.
REQ-026 Reset asserted mid-burst SHALL abort the burst and discard all buffered words; first cycle after release in_ready=1.

Configuration
REQ-027 Macro VR_BURST_FLUSH_EN defined: idle counter increments each cycle in IDLE with 0 < level < BURST_LEN and no push, clears on any push or state exit; at FLUSH_CYCLES, SHALL enter FLUSH, emitting a short burst of length = level at entry (pushes during FLUSH are not included), out_blast on its last beat, then IDLE.
REQ-028 Macro undefined: no FLUSH state, no idle counter; partial data waits indefinitely for BURST_LEN words.

Structure
REQ-029 Package vr_burst_pkg SHALL hold the state enum typedef and level/counter width helper constants.
REQ-030 FIFO storage/pointers SHALL be sub-module vr_burst_fifo (sync, first-word fall-through, full/empty/level); framer FSM in top.

Verification (defaults unless noted)
REQ-031 Push 8 words 0x0001..0x0008, out_bready=1 -> one burst of 8 contiguous beats 0x0001..0x0008, out_blast on 0x0008 only, level returns 0.
REQ-032 Push 16 words back-to-back, out_bready=1 -> two bursts, no out_bvalid gap between them, out_blast on beats 8 and 16.
REQ-033 Push 40 words, out_bready=0 -> in_ready=0 after level=32, words 33..40 held upstream; release out_bready -> all 40 delivered in order, 5 bursts.
REQ-034 Mid-burst out_bready toggled 1/0 every cycle -> out_bdata/out_blast stable during stalls, order preserved.
REQ-035 VR_BURST_FLUSH_EN, push 3 words then idle -> after 64 idle cycles a 3-beat burst with out_blast on beat 3; without macro -> no output.
REQ-036 Assert rst_n=0 after beat 4 of a burst -> outputs to reset values, level=0; post-reset push 8 words -> clean 8-beat burst.
